// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM port controller: FSM states, grant encoding and
// strobe-counter sizing.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    GNT_A   = 2'd0,
    GNT_B   = 2'd1,
    GNT_CLR = 2'd2
  } grant_e;

  localparam int STROBE_CNT_BITS = 4;

  // Strobe length clamped into the range the 4-bit down-counter can express.
  function automatic logic [STROBE_CNT_BITS-1:0] eff_wait(input int w);
    if (w < 1) begin
      return 4'd1;
    end else if (w > 15) begin
      return 4'd15;
    end else begin
      return w[STROBE_CNT_BITS-1:0];
    end
  endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// Sweep-clear sequencer: busy flag, address counter with wrap detect and a
// one-cycle done pulse. Only instantiated when SRAM_CLEAR_EN is defined.
module sram_clear_seq
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 start,
  input  logic                 step,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS-1:0] addr
);

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      addr_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      addr_q <= addr_d;
    end
  end

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    addr_d = addr_q;
    if (start && !busy_q) begin
      busy_d = 1'b1;
      addr_d = '0;
    end
    // step fires on the STROBE->HOLD edge, so done lands in the HOLD cycle
    if (step && busy_q) begin
      addr_d = addr_q + ADDR_BITS'(1);
      if (addr_q == {ADDR_BITS{1'b1}}) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign addr = addr_q;

endmodule

// File: rtl/sram_port_ctrl.sv
// Two-client (video read A, CPU read/write B) front end for an async SRAM.
// Optional sweep-clear engine is enabled with `define SRAM_CLEAR_EN.
module sram_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int                   DATA_BITS   = 8,
  parameter int                   ADDR_BITS   = 11,
  parameter int                   WAIT_CYCLES = 1,
  parameter logic [DATA_BITS-1:0] CLEAR_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 a_req,
  input  logic [ADDR_BITS-1:0] a_addr,
  output logic                 a_ack,
  output logic [DATA_BITS-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [DATA_BITS-1:0] b_wdata,
  output logic                 b_ack,
  output logic [DATA_BITS-1:0] b_rdata,
  input  logic                 clear_start,
  output logic                 clear_busy,
  output logic                 clear_done,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic                 sram_nen,
  output logic                 sram_nwe,
  output logic [DATA_BITS-1:0] sram_din,
  input  logic [DATA_BITS-1:0] sram_dout
);

  localparam logic [STROBE_CNT_BITS-1:0] STROBE_LOAD =
    eff_wait(WAIT_CYCLES) - STROBE_CNT_BITS'(1);

  state_e                     state_q, state_d;
  grant_e                     grant_q, grant_d;
  grant_e                     last_grant_q, last_grant_d;
  logic                       we_q, we_d;
  logic [STROBE_CNT_BITS-1:0] cnt_q, cnt_d;

  logic [ADDR_BITS-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_BITS-1:0] sram_din_q, sram_din_d;
  logic                 sram_nen_q, sram_nen_d;
  logic                 sram_nwe_q, sram_nwe_d;
  logic                 a_ack_q, a_ack_d;
  logic                 b_ack_q, b_ack_d;
  logic [DATA_BITS-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_BITS-1:0] b_rdata_q, b_rdata_d;

  logic                 clr_busy;
  logic [ADDR_BITS-1:0] clr_addr;
  logic                 strobe_last;

  assign strobe_last = (state_q == STROBE) && (cnt_q == '0);

`ifdef SRAM_CLEAR_EN
  logic clr_step;
  assign clr_step = strobe_last && (grant_q == GNT_CLR);

  sram_clear_seq #(
    .ADDR_BITS(ADDR_BITS)
  ) u_clear_seq (
    .clk   (clk),
    .nreset(nreset),
    .start (clear_start),
    .step  (clr_step),
    .busy  (clr_busy),
    .done  (clear_done),
    .addr  (clr_addr)
  );
  assign clear_busy = clr_busy;
`else
  logic unused_clear_start;
  assign unused_clear_start = clear_start;
  assign clr_busy   = 1'b0;
  assign clr_addr   = '0;
  assign clear_busy = 1'b0;
  assign clear_done = 1'b0;
`endif

  // Async reset pulls nen/nwe high at once, aborting any write in flight.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      grant_q      <= GNT_B;
      last_grant_q <= GNT_B;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      sram_addr_q  <= '0;
      sram_din_q   <= '0;
      sram_nen_q   <= 1'b1;
      sram_nwe_q   <= 1'b1;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      sram_addr_q  <= sram_addr_d;
      sram_din_q   <= sram_din_d;
      sram_nen_q   <= sram_nen_d;
      sram_nwe_q   <= sram_nwe_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_busy) begin
          grant_d = GNT_CLR;
          we_d    = 1'b1;
          state_d = SETUP;
        end else if (a_req && (!b_req || (last_grant_q == GNT_B))) begin
          grant_d      = GNT_A;
          last_grant_d = GNT_A;
          we_d         = 1'b0;
          state_d      = SETUP;
        end else if (b_req) begin
          grant_d      = GNT_B;
          last_grant_d = GNT_B;
          we_d         = b_we;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = STROBE_LOAD;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - STROBE_CNT_BITS'(1);
        end
      end
      HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered: each branch computes the value for the next state.
  always_comb begin
    sram_addr_d = sram_addr_q;
    sram_din_d  = sram_din_q;
    sram_nen_d  = sram_nen_q;
    sram_nwe_d  = sram_nwe_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    case (state_q)
      IDLE: begin
        if (state_d == SETUP) begin
          sram_nen_d = 1'b0;
          sram_nwe_d = 1'b1;
          case (grant_d)
            GNT_A: sram_addr_d = a_addr;
            GNT_B: begin
              sram_addr_d = b_addr;
              sram_din_d  = b_wdata;
            end
            GNT_CLR: begin
              sram_addr_d = clr_addr;
              sram_din_d  = CLEAR_VALUE;
            end
            default: sram_addr_d = sram_addr_q;
          endcase
        end
      end
      SETUP: sram_nwe_d = ~we_q;
      STROBE: begin
        if (strobe_last) begin
          sram_nwe_d = 1'b1;
          if (grant_q == GNT_A) begin
            a_ack_d   = 1'b1;
            a_rdata_d = sram_dout;
          end else if (grant_q == GNT_B) begin
            b_ack_d = 1'b1;
            if (!we_q) begin
              b_rdata_d = sram_dout;
            end
          end
        end
      end
      HOLD: begin
        sram_nen_d = 1'b1;
        sram_nwe_d = 1'b1;
      end
      default: begin
        sram_nen_d = 1'b1;
        sram_nwe_d = 1'b1;
      end
    endcase
  end

  assign sram_addr = sram_addr_q;
  assign sram_din  = sram_din_q;
  assign sram_nen  = sram_nen_q;
  assign sram_nwe  = sram_nwe_q;
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: two instances (strobe 1 and 3 clocks), each with a
// behavioural async SRAM. Clear-engine checks follow SRAM_CLEAR_EN.
module tb_sram_port_ctrl;

  logic clk = 1'b0;
  logic nreset;
  logic preload;

  logic [1:0]  a_req, b_req, b_we, clear_start;
  logic [10:0] a_addr [2];
  logic [10:0] b_addr [2];
  logic [7:0]  b_wdata [2];
  logic [1:0]  a_ack, b_ack, clear_busy, clear_done, sram_nen, sram_nwe;
  logic [7:0]  a_rdata [2];
  logic [7:0]  b_rdata [2];
  logic [7:0]  sram_din [2];
  logic [7:0]  sram_dout [2];
  logic [10:0] sram_addr [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [7:0] mem [2048];

    sram_port_ctrl #(
      .DATA_BITS  (8),
      .ADDR_BITS  (11),
      .WAIT_CYCLES((gi == 0) ? 1 : 3),
      .CLEAR_VALUE(8'h00)
    ) u_dut (
      .clk        (clk),
      .nreset     (nreset),
      .a_req      (a_req[gi]),
      .a_addr     (a_addr[gi]),
      .a_ack      (a_ack[gi]),
      .a_rdata    (a_rdata[gi]),
      .b_req      (b_req[gi]),
      .b_we       (b_we[gi]),
      .b_addr     (b_addr[gi]),
      .b_wdata    (b_wdata[gi]),
      .b_ack      (b_ack[gi]),
      .b_rdata    (b_rdata[gi]),
      .clear_start(clear_start[gi]),
      .clear_busy (clear_busy[gi]),
      .clear_done (clear_done[gi]),
      .sram_addr  (sram_addr[gi]),
      .sram_nen   (sram_nen[gi]),
      .sram_nwe   (sram_nwe[gi]),
      .sram_din   (sram_din[gi]),
      .sram_dout  (sram_dout[gi])
    );

    assign sram_dout[gi] = mem[sram_addr[gi]];

    always @(negedge clk) begin
      if (preload) begin
        for (int i = 0; i < 2048; i++) mem[i] <= 8'h80 | {1'b0, i[6:0]};
      end else if (!sram_nen[gi] && !sram_nwe[gi]) begin
        mem[sram_addr[gi]] <= sram_din[gi];
      end
    end
  end

  typedef struct {
    bit         port_b;
    bit         we;
    logic [10:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    int         exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One access on instance d; called just after a clock edge.
  task automatic do_access(input int d, input string name, input bit port_b, input bit we,
                           input logic [10:0] addr, input logic [7:0] wdata,
                           input bit chk_data, input logic [7:0] exp_rdata,
                           input int exp_lat, output logic [7:0] got);
    int lat = 0;
    int nen_low = 0;
    int nwe_low = 0;
    int addr_bad = 0;
    int other_ack = 0;
    int w = (d == 0) ? 1 : 3;
    bit done = 0;
    if (port_b) begin
      b_we[d] = we; b_addr[d] = addr; b_wdata[d] = wdata; b_req[d] = 1'b1;
    end else begin
      a_addr[d] = addr; a_req[d] = 1'b1;
    end
    for (int n = 1; n <= 20 && !done; n++) begin
      @(posedge clk); #1;
      if (!sram_nen[d]) begin
        nen_low++;
        if (sram_addr[d] !== addr || (we && sram_din[d] !== wdata)) addr_bad++;
      end
      if (!sram_nwe[d]) nwe_low++;
      if (port_b ? a_ack[d] : b_ack[d]) other_ack++;
      if (port_b ? b_ack[d] : a_ack[d]) begin
        done = 1;
        lat = n;
      end
    end
    a_req[d] = 1'b0;
    b_req[d] = 1'b0;
    got = port_b ? b_rdata[d] : a_rdata[d];
    $display("access %s dut%0d port=%s we=%0d addr=%03h lat=%0d rdata=%02h",
             name, d, port_b ? "B" : "A", we, addr, lat, got);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_nen_cycles"}, nen_low, 2 + w);
    check({name, "_nwe_cycles"}, nwe_low, we ? w : 0);
    check({name, "_addr_stable"}, addr_bad, 0);
    check({name, "_other_ack"}, other_ack, 0);
    if (chk_data && !we) check({name, "_rdata"}, got, exp_rdata);
  endtask

  // Both ports request on instance 0 until n acks; grants must alternate.
  task automatic round_robin(input string name, input int n, input bit first_b);
    int acks = 0;
    int order_bad = 0;
    int coinc = 0;
    bit expect_b = first_b;
    a_addr[0] = 11'h123;
    b_addr[0] = 11'h000; b_we[0] = 1'b0;
    a_req[0] = 1'b1; b_req[0] = 1'b1;
    for (int c = 0; c < 60 && acks < n; c++) begin
      @(posedge clk); #1;
      if (a_ack[0] && b_ack[0]) coinc++;
      if (a_ack[0] || b_ack[0]) begin
        $display("rr %s ack%0d port=%s", name, acks, b_ack[0] ? "B" : "A");
        if (b_ack[0] != expect_b) order_bad++;
        expect_b = !expect_b;
        acks++;
      end
    end
    a_req[0] = 1'b0; b_req[0] = 1'b0;
    check({name, "_acks"}, acks, n);
    check({name, "_order"}, order_bad, 0);
    check({name, "_coincide"}, coinc, 0);
    check({name, "_a_rdata"}, a_rdata[0], 8'hA5);
    check({name, "_b_rdata"}, b_rdata[0], 8'h11);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] got;
    logic [7:0] exp_a_last;
    logic [7:0] exp_b_last;
    int ack_seen;

    vecs[0] = '{1'b1, 1'b1, 11'h123, 8'h5A, 8'h00, 3};
    vecs[1] = '{1'b0, 1'b0, 11'h123, 8'h00, 8'h5A, 4};
    vecs[2] = '{1'b1, 1'b1, 11'h7FF, 8'hC3, 8'h00, 4};
    vecs[3] = '{1'b1, 1'b1, 11'h000, 8'h11, 8'h00, 4};
    vecs[4] = '{1'b0, 1'b0, 11'h7FF, 8'h00, 8'hC3, 4};
    vecs[5] = '{1'b1, 1'b0, 11'h000, 8'h00, 8'h11, 4};
    vecs[6] = '{1'b1, 1'b1, 11'h123, 8'hA5, 8'h00, 4};
    vecs[7] = '{1'b1, 1'b0, 11'h123, 8'h00, 8'hA5, 4};
    vecs[8] = '{1'b1, 1'b0, 11'h055, 8'h00, 8'hD5, 4};
    vecs[9] = '{1'b0, 1'b0, 11'h000, 8'h00, 8'h11, 4};

    a_req = '0; b_req = '0; b_we = '0; clear_start = '0;
    for (int d = 0; d < 2; d++) begin
      a_addr[d] = '0; b_addr[d] = '0; b_wdata[d] = '0;
    end
    nreset = 1'b0;
    preload = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_nen", sram_nen[0], 1'b1);
    check("rst_nwe", sram_nwe[0], 1'b1);
    check("rst_addr", sram_addr[0], 11'h000);
    check("rst_din", sram_din[0], 8'h00);
    check("rst_acks", {a_ack[0], b_ack[0]}, 2'b00);
    check("rst_rdata", {a_rdata[0], b_rdata[0]}, 16'h0000);
    check("rst_clear", {clear_busy[0], clear_done[0]}, 2'b00);
    preload = 1'b0;
    nreset = 1'b1;

    exp_a_last = 8'h00;
    exp_b_last = 8'h00;
    for (int i = 0; i < 10; i++) begin
      do_access(0, $sformatf("vec%0d", i), vecs[i].port_b, vecs[i].we, vecs[i].addr,
                vecs[i].wdata, 1'b1, vecs[i].exp_rdata, vecs[i].exp_lat, got);
      if (!vecs[i].we) begin
        if (vecs[i].port_b) exp_b_last = vecs[i].exp_rdata;
        else exp_a_last = vecs[i].exp_rdata;
      end
      check($sformatf("vec%0d_hold_a", i), a_rdata[0], exp_a_last);
      check($sformatf("vec%0d_hold_b", i), b_rdata[0], exp_b_last);
    end

    round_robin("rr4", 4, 1'b1);

    // Three-clock strobe instance
    do_access(1, "w3_wr", 1'b1, 1'b1, 11'h010, 8'h77, 1'b1, 8'h00, 5, got);
    do_access(1, "w3_rd", 1'b0, 1'b0, 11'h010, 8'h00, 1'b1, 8'h77, 6, got);
    do_access(1, "w3_rd_pre", 1'b1, 1'b0, 11'h0AA, 8'h00, 1'b1, 8'hAA, 6, got);
    @(posedge clk); #1;

    // Reset in the middle of a write strobe
    b_we[0] = 1'b1; b_addr[0] = 11'h200; b_wdata[0] = 8'h99; b_req[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_nwe_low", sram_nwe[0], 1'b0);
    #1;
    nreset = 1'b0;
    b_req[0] = 1'b0;
    #1;
    check("mid_rst_nwe", sram_nwe[0], 1'b1);
    check("mid_rst_nen", sram_nen[0], 1'b1);
    ack_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      ack_seen += b_ack[0];
    end
    nreset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      ack_seen += b_ack[0];
    end
    check("mid_rst_no_ack", ack_seen, 0);
    check("mid_rst_addr", sram_addr[0], 11'h000);
    check("mid_rst_rdata", {a_rdata[0], b_rdata[0]}, 16'h0000);
    round_robin("rr_post_rst", 2, 1'b0);
    do_access(0, "post_rst_rd", 1'b1, 1'b0, 11'h200, 8'h00, 1'b0, 8'h00, 4, got);
    check("post_rst_word", (!$isunknown(got)) && (got == 8'h80 || got == 8'h99), 1'b1);
    @(posedge clk); #1;

`ifdef SRAM_CLEAR_EN
    begin
      int done_cyc = -1;
      int ack_cyc = -1;
      int done_cnt = 0;
      int early = 0;
      int nonclear = 0;
      b_we[0] = 1'b1; b_addr[0] = 11'h300; b_wdata[0] = 8'h42; b_req[0] = 1'b1;
      @(posedge clk); #1;
      clear_start[0] = 1'b1;
      @(posedge clk); #1;
      clear_start[0] = 1'b0;
      check("clr_busy_set", clear_busy[0], 1'b1);
      check("clr_no_early_wr_ack", b_ack[0], 1'b0);
      @(posedge clk); #1;
      check("clr_wr_ack_first", b_ack[0], 1'b1);
      b_we[0] = 1'b0;
      for (int n = 1; n <= 8300 && ack_cyc < 0; n++) begin
        @(posedge clk); #1;
        if (clear_done[0]) begin
          done_cnt++;
          done_cyc = n;
        end
        if (b_ack[0]) begin
          if (done_cyc < 0) early++;
          else ack_cyc = n;
        end
      end
      b_req[0] = 1'b0;
      $display("clear sweep done_cyc=%0d ack_cyc=%0d rdata=%02h", done_cyc, ack_cyc, b_rdata[0]);
      check("clr_sweep_len", done_cyc, 8192);
      check("clr_done_once", done_cnt, 1);
      check("clr_no_early_ack", early, 0);
      check("clr_pending_ack", ack_cyc, 8196);
      check("clr_read_value", b_rdata[0], 8'h00);
      check("clr_busy_end", clear_busy[0], 1'b0);
      for (int i = 0; i < 2048; i++) if (g_dut[0].mem[i] !== 8'h00) nonclear++;
      check("clr_all_words", nonclear, 0);
    end
`else
    begin
      int busy_seen = 0;
      clear_start[0] = 1'b1;
      @(posedge clk); #1;
      clear_start[0] = 1'b0;
      repeat (4) begin
        busy_seen += clear_busy[0] + clear_done[0];
        @(posedge clk); #1;
      end
      $display("clear disabled busy_seen=%0d", busy_seen);
      check("noclr_busy", busy_seen, 0);
      do_access(0, "noclr_rd", 1'b1, 1'b0, 11'h123, 8'h00, 1'b1, 8'hA5, 3, got);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
